// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types: the buffered PC pair, the fetch FSM states and the reset vector.
package rv32i_types;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;

    typedef struct packed {
        logic [31:0] fetch_pc_curr;
        logic [31:0] fetch_pc_next;
    } fetch_output_reg_t;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Single-outstanding instruction fetch with a one-entry decode buffer and
// redirect handling that drops responses to pre-redirect requests.
module fetch_stage
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic [31:0]       imem_addr,
    output logic [3:0]        imem_rmask,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_resp,
    input  logic              stall_inst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output fetch_output_reg_t fetch_output,
    output logic [31:0]       inst_rdata,
    output logic              inst_valid
);

    fetch_state_t      state_q;
    logic [31:0]       pc_q;
    logic              discard_q;
    logic              inst_valid_q;
    logic [31:0]       inst_rdata_q;
    fetch_output_reg_t fetch_output_q;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;
    logic        fetch_req;

    assign pc_plus4     = pc_q + 32'd4;
    assign redirect_tgt = word_align(redirect_pc);

    // Gated by rst so the request pulse is suppressed while reset is held.
    assign fetch_req = rst && ((state_q == FETCH_REQ) ||
                               (state_q == FETCH_HOLD && !stall_inst && !redirect_valid));

    assign imem_rmask   = fetch_req ? 4'hF : 4'h0;
    assign imem_addr    = pc_q;
    assign inst_valid   = inst_valid_q;
    assign inst_rdata   = inst_rdata_q;
    assign fetch_output = fetch_output_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= FETCH_REQ;
            pc_q           <= RESET_PC;
            discard_q      <= 1'b0;
            inst_valid_q   <= 1'b0;
            inst_rdata_q   <= '0;
            fetch_output_q <= '0;
        end else if (redirect_valid) begin
            pc_q         <= redirect_tgt;
            inst_valid_q <= 1'b0;
            case (state_q)
                FETCH_REQ: begin
                    state_q   <= FETCH_WAIT;
                    discard_q <= 1'b1;
                end
                FETCH_WAIT: begin
                    // A response landing with the redirect retires the stale request.
                    if (imem_resp) begin
                        state_q   <= FETCH_REQ;
                        discard_q <= 1'b0;
                    end else begin
                        discard_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= FETCH_REQ;
                end
            endcase
        end else begin
            case (state_q)
                FETCH_REQ: begin
                    state_q <= FETCH_WAIT;
                end
                FETCH_WAIT: begin
                    if (imem_resp && discard_q) begin
                        discard_q <= 1'b0;
                        state_q   <= FETCH_REQ;
                    end else if (imem_resp) begin
                        inst_rdata_q                 <= imem_rdata;
                        fetch_output_q.fetch_pc_curr <= pc_q;
                        fetch_output_q.fetch_pc_next <= pc_plus4;
                        inst_valid_q                 <= 1'b1;
                        pc_q                         <= pc_plus4;
                        state_q                      <= FETCH_HOLD;
                    end
                end
                FETCH_HOLD: begin
                    if (!stall_inst) begin
                        inst_valid_q <= 1'b0;
                        state_q      <= FETCH_WAIT;
                    end
                end
                default: begin
                    state_q <= FETCH_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural memory plus an expected
// instruction stream (sequential addresses restarted at each redirect).
module tb_fetch_stage;
    import rv32i_types::*;

    localparam logic [31:0] RESET_PC = 32'h1eceb000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [31:0]       imem_addr;
    logic [3:0]        imem_rmask;
    logic [31:0]       imem_rdata;
    logic              imem_resp;
    logic              stall_inst;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    fetch_output_reg_t fetch_output;
    logic [31:0]       inst_rdata;
    logic              inst_valid;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rmask     (imem_rmask),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .stall_inst     (stall_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_output   (fetch_output),
        .inst_rdata     (inst_rdata),
        .inst_valid     (inst_valid)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    bit          stallV = 1'b0;
    bit          redirV = 1'b0;
    logic [31:0] redirPcV = '0;

    bit          memPending = 1'b0;
    int          memCnt = 0;
    int          memLat = 1;
    logic [31:0] memAddr = '0;

    exp_t        expQ[$];
    logic [31:0] expNext = RESET_PC;
    int          consumed = 0;

    logic [3:0]        sRmask;
    logic [31:0]       sAddr;
    logic              sValid;
    logic [31:0]       sRdata;
    fetch_output_reg_t sOut;
    bit                seenValid;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic refill();
        exp_t e;
        while (expQ.size() < 8) begin
            e.pc   = expNext;
            e.data = memWord(expNext);
            expQ.push_back(e);
            expNext = expNext + 32'd4;
        end
    endtask

    // One bench cycle: drive inputs and memory at negedge, then sample outputs.
    task automatic applyStimulus();
        @(negedge clk);
        stall_inst     = stallV;
        redirect_valid = redirV;
        redirect_pc    = redirPcV;
        imem_resp      = 1'b0;
        imem_rdata     = $urandom;
        if (!rst) begin
            memPending = 1'b0;
            expQ.delete();
            expNext = RESET_PC;
        end else if (memPending) begin
            memCnt--;
            if (memCnt == 0) begin
                imem_resp  = 1'b1;
                imem_rdata = memWord(memAddr);
                memPending = 1'b0;
            end
        end
        if (rst && redirV) begin
            expQ.delete();
            expNext = {redirPcV[31:2], 2'b00};
        end
        refill();
        #1;
        sRmask = imem_rmask;
        sAddr  = imem_addr;
        sValid = inst_valid;
        sRdata = inst_rdata;
        sOut   = fetch_output;
        if (sValid) seenValid = 1'b1;
        if (rst && imem_rmask == 4'hF) begin
            checkBit("single_outstanding", memPending, 1'b0);
            memPending = 1'b1;
            memCnt     = memLat;
            memAddr    = imem_addr;
        end
    endtask

    task automatic waitReq(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            applyStimulus();
            if (sRmask == 4'hF) return;
        end
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: no request within %0d cycles", name, budget);
    endtask

    task automatic waitValid(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            applyStimulus();
            if (sValid) return;
        end
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: no inst_valid within %0d cycles", name, budget);
    endtask

    // Monitor: pops the expected stream whenever decode consumes an instruction.
    initial begin
        logic              prevValid;
        logic              prevStall;
        logic              prevRedir;
        logic [31:0]       prevRdata;
        fetch_output_reg_t prevOut;
        exp_t              e;
        prevValid = 1'b0;
        prevStall = 1'b0;
        prevRedir = 1'b0;
        prevRdata = '0;
        prevOut   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                prevValid = 1'b0;
                prevStall = 1'b0;
                prevRedir = 1'b0;
            end else begin
                if (prevRedir) checkBit("valid_after_redirect", inst_valid, 1'b0);
                if (prevValid && prevStall && !prevRedir) begin
                    checkBit("hold_valid", inst_valid, 1'b1);
                    checkOutput("hold_rdata", inst_rdata, prevRdata);
                    checkOutput("hold_pc_curr", fetch_output.fetch_pc_curr, prevOut.fetch_pc_curr);
                end
                if (inst_valid && !redirect_valid) begin
                    if (stall_inst) begin
                        checkOutput("stall_no_req", 32'(imem_rmask), 32'h0);
                    end else if (expQ.size() == 0) begin
                        nChecks++;
                        nFails++;
                        $display("[TB] FAIL scoreboard_empty: got pc %08h expected none", fetch_output.fetch_pc_curr);
                    end else begin
                        e = expQ.pop_front();
                        consumed++;
                        checkOutput("sb_pc_curr", fetch_output.fetch_pc_curr, e.pc);
                        checkOutput("sb_pc_next", fetch_output.fetch_pc_next, e.pc + 32'd4);
                        checkOutput("sb_rdata", inst_rdata, e.data);
                        checkOutput("release_rmask", 32'(imem_rmask), 32'hF);
                        checkOutput("release_addr", imem_addr, e.pc + 32'd4);
                    end
                end
                if (imem_rmask != 4'h0) begin
                    checkOutput("rmask_legal", 32'(imem_rmask), 32'hF);
                    checkOutput("addr_aligned", 32'(imem_addr[1:0]), 32'h0);
                end
                prevValid = inst_valid;
                prevStall = stall_inst;
                prevRedir = redirect_valid;
                prevRdata = inst_rdata;
                prevOut   = fetch_output;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0]       reqs[$];
        logic [31:0]       firstCurr;
        logic [31:0]       firstNext;
        bit                gotFirst;
        logic [31:0]       capRdata;
        fetch_output_reg_t capOut;

        imem_resp      = 1'b0;
        imem_rdata     = '0;
        stall_inst     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset values while rst is held low
        repeat (3) applyStimulus();
        checkOutput("rst_rmask", 32'(sRmask), 32'h0);
        checkOutput("rst_addr", sAddr, RESET_PC);
        checkBit("rst_valid", sValid, 1'b0);
        checkOutput("rst_rdata", sRdata, 32'h0);
        checkOutput("rst_pc_curr", sOut.fetch_pc_curr, 32'h0);
        checkOutput("rst_pc_next", sOut.fetch_pc_next, 32'h0);

        // Release with a 1-cycle memory: sequential fetch order
        memLat = 1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        gotFirst = 1'b0;
        firstCurr = '0;
        firstNext = '0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus();
            if (sRmask == 4'hF) reqs.push_back(sAddr);
            if (sValid && !gotFirst) begin
                gotFirst  = 1'b1;
                firstCurr = sOut.fetch_pc_curr;
                firstNext = sOut.fetch_pc_next;
            end
        end
        checkBit("boot_req_count", reqs.size() >= 3, 1'b1);
        if (reqs.size() >= 3) begin
            checkOutput("boot_req0", reqs[0], 32'h1eceb000);
            checkOutput("boot_req1", reqs[1], 32'h1eceb004);
            checkOutput("boot_req2", reqs[2], 32'h1eceb008);
        end
        checkBit("boot_first_valid", gotFirst, 1'b1);
        checkOutput("boot_pc_curr", firstCurr, 32'h1eceb000);
        checkOutput("boot_pc_next", firstNext, 32'h1eceb004);

        // Stall held for 5 cycles in HOLD
        stallV = 1'b1;
        waitValid("stall_wait", 12);
        capRdata = sRdata;
        capOut   = sOut;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) applyStimulus();
            checkOutput("stall_rmask", 32'(sRmask), 32'h0);
            checkOutput("stall_rdata", sRdata, capRdata);
            checkOutput("stall_pc_curr", sOut.fetch_pc_curr, capOut.fetch_pc_curr);
            checkOutput("stall_pc_next", sOut.fetch_pc_next, capOut.fetch_pc_next);
        end
        stallV = 1'b0;
        applyStimulus();
        checkOutput("stall_release_rmask", 32'(sRmask), 32'hF);
        checkOutput("stall_release_addr", sAddr, capOut.fetch_pc_curr + 32'd4);
        stallV = 1'b1;
        applyStimulus();
        checkOutput("stall_single_req", 32'(sRmask), 32'h0);
        stallV = 1'b0;

        // Redirect while WAIT, stale response arrives 3 cycles later
        memLat = 4;
        waitReq("redir_wait_req", 12);
        memLat = 1;
        redirV = 1'b1;
        redirPcV = 32'h1eceb103;
        applyStimulus();
        redirV = 1'b0;
        seenValid = 1'b0;
        waitReq("redir_new_req", 12);
        checkBit("redir_no_stale_valid", seenValid, 1'b0);
        checkOutput("redir_req_addr", sAddr, 32'h1eceb100);
        waitValid("redir_valid", 12);
        checkOutput("redir_pc_curr", sOut.fetch_pc_curr, 32'h1eceb100);

        // Redirect in the same cycle as a response
        memLat = 2;
        waitReq("same_cycle_req", 12);
        memLat = 1;
        applyStimulus();
        redirV = 1'b1;
        redirPcV = 32'h0000_4000;
        applyStimulus();
        redirV = 1'b0;
        applyStimulus();
        checkBit("same_cycle_no_valid", sValid, 1'b0);
        checkOutput("same_cycle_rmask", 32'(sRmask), 32'hF);
        checkOutput("same_cycle_addr", sAddr, 32'h0000_4000);

        // PC wrap at the top of the address space
        redirV = 1'b1;
        redirPcV = 32'hFFFF_FFFC;
        applyStimulus();
        redirV = 1'b0;
        waitValid("wrap_valid", 16);
        checkOutput("wrap_pc_curr", sOut.fetch_pc_curr, 32'hFFFF_FFFC);
        checkOutput("wrap_pc_next", sOut.fetch_pc_next, 32'h0000_0000);
        checkOutput("wrap_req_rmask", 32'(sRmask), 32'hF);
        checkOutput("wrap_req_addr", sAddr, 32'h0000_0000);

        // Asynchronous reset while WAIT
        memLat = 3;
        waitReq("rst_mid_req", 12);
        applyStimulus();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_rmask", 32'(imem_rmask), 32'h0);
        checkOutput("rst_mid_addr", imem_addr, RESET_PC);
        checkBit("rst_mid_valid", inst_valid, 1'b0);
        checkOutput("rst_mid_rdata", inst_rdata, 32'h0);
        checkOutput("rst_mid_pc_curr", fetch_output.fetch_pc_curr, 32'h0);
        repeat (2) applyStimulus();
        memLat = 1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus();
        checkOutput("rst_rel_rmask", 32'(sRmask), 32'hF);
        checkOutput("rst_rel_addr", sAddr, RESET_PC);

        // Randomized traffic against the scoreboard
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            stallV = ($urandom_range(0, 99) < 30);
            redirV = ($urandom_range(0, 99) < 4);
            redirPcV = $urandom;
            if ($urandom_range(0, 7) == 0) redirPcV = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            memLat = $urandom_range(1, 4);
            applyStimulus();
        end
        stallV = 1'b0;
        redirV = 1'b0;
        repeat (10) applyStimulus();
        checkBit("random_progress", consumed >= 200, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h1eceb000, is the first fetch address after reset; bits [1:0] are zero.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 imem_addr  output  32  fetch address, word aligned, valid while imem_rmask != 0.
REQ-005 imem_rmask  output  4  one-cycle request pulse, 4'hF = fetch, 4'h0 = idle.
REQ-006 imem_rdata  input  32  instruction word, valid only when imem_resp = 1.
REQ-007 imem_resp  input  1  one-cycle response pulse for the single outstanding request.
REQ-008 stall_inst  input  1  decode cannot accept the buffered instruction this cycle.
REQ-009 redirect_valid  input  1  one-cycle pulse to flush and refetch from redirect_pc.
REQ-010 redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 00.
REQ-011 fetch_output  output  fetch_output_reg_t  {fetch_pc_curr, fetch_pc_next} of the buffered instruction.
REQ-012 inst_rdata  output  32  buffered instruction word.
REQ-013 inst_valid  output  1  buffer holds an instruction for decode.

Function
REQ-014 The block keeps at most one imem request outstanding at any time.
REQ-015 States:
- REQ: issue a request at pc; next state WAIT.
- WAIT: await imem_resp.
- HOLD: buffer full, waiting for decode.
REQ-016 REQ drives imem_rmask = 4'hF and imem_addr = pc for exactly that cycle, then transitions to WAIT.
REQ-017 WAIT with imem_resp = 1 and discard = 0, on the next edge:
- inst_rdata <= imem_rdata; fetch_pc_curr <= pc; fetch_pc_next <= pc + 4.
- inst_valid <= 1; pc <= pc + 4; next state HOLD.
REQ-018 HOLD with stall_inst = 1: buffer contents and inst_valid are held unchanged, and no request is issued.
REQ-019 HOLD with stall_inst = 0 (instruction consumed):
- same cycle: imem_rmask = 4'hF at pc.
- next edge: inst_valid <= 0; next state WAIT.
REQ-020 Latency: imem_resp at edge N sets inst_valid visible after edge N; back-to-back throughput is one instruction per (memory latency + 1) cycles.
REQ-021 pc arithmetic is modulo 2^32; 32'hFFFFFFFC + 4 wraps to 32'h00000000 without error.
REQ-022 redirect_valid = 1 has priority over stall_inst and over a normal response; on the next edge pc <= {redirect_pc[31:2], 2'b00} and inst_valid <= 0.
REQ-023 Redirect next state and discard flag, by current state:
- in HOLD: next state REQ; no request is issued that cycle.
- in REQ: the pulse still issues at the old pc; next state WAIT with discard <= 1.
- in WAIT with imem_resp = 0: stay in WAIT with discard <= 1.
- in WAIT with imem_resp = 1: drop the response; next state REQ; discard <= 0.
REQ-024 WAIT with discard = 1 and imem_resp = 1: drop the response, clear discard, next state REQ; nothing is ever written to the buffer from a discarded response.
REQ-025 A redirect while discard = 1 updates pc again and leaves discard = 1.
REQ-026 inst_valid never asserts for an address fetched before the most recent redirect.

Reset
REQ-027 While rst = 0, outputs are:
- imem_rmask = 4'h0; imem_addr = RESET_PC.
- inst_valid = 0; inst_rdata = 0; fetch_output = 0.
REQ-028 Internal reset values: pc = RESET_PC, state = REQ, discard = 0; the first request issues in the first cycle after rst deasserts.
REQ-029 Reset asserted mid-transaction abandons the outstanding request; a late imem_resp after reset release is ignored unless the state is WAIT.

Structure
REQ-030 fetch_output_reg_t, the state enum and RESET_PC's default belong in rv32i_types; no sub-module is required.

Verification
REQ-031 Reset release, 1-cycle memory: imem_addr 1eceb000, 1eceb004, 1eceb008 in order; fetch_pc_curr/pc_next = 1eceb000/1eceb004 on the first inst_valid.
REQ-032 stall_inst held 5 cycles in HOLD: inst_rdata and fetch_output are stable and imem_rmask = 0 throughout; one request follows release.
REQ-033 Redirect to 32'h1eceb103 while in WAIT, with resp 3 cycles later: that response is dropped, the next request is at 1eceb100, and the first inst_valid shows pc_curr 1eceb100.
REQ-034 Redirect and imem_resp in the same cycle: no inst_valid, and the next-cycle request goes to the target.
REQ-035 pc = FFFFFFFC response: fetch_pc_next = 00000000, and the next request is at 00000000.
REQ-036 rst pulsed low while in WAIT: outputs are at reset values immediately, and the first request after release is at RESET_PC.
